// File: rtl/func.sv
// Iterative unit computing y = floor(sqrt(a + floor(cbrt(b)))) for 8-bit unsigned a, b.
// Latency: fixed 11 cycles from the start edge to busy_o == 00, independent of data.
// No backpressure: start_i is ignored while busy; the master polls busy_o before issuing start.
module func (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] a_bi,
    input  logic [7:0] b_bi,
    input  logic       start_i,
    output logic [1:0] busy_o,
    output logic [4:0] y_bo
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CBRT = 2'b01,
        SQRT = 2'b10
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  step;
    logic [7:0]  a_q;
    logic [7:0]  rem_q;
    logic [2:0]  cr_q;
    logic [5:0]  prod_q;
    logic [8:0]  num_q;
    logic [8:0]  m_q;
    logic [9:0]  res_q;

    logic        last_cbrt, last_sqrt;
    logic [5:0]  y2w, prod_full;
    logic [7:0]  t, rem_sh, rem_nxt;
    logic [2:0]  shamt, cr_nxt;
    logic        fit_c;
    logic [8:0]  sum;
    logic [9:0]  trial, res_nxt;
    logic [8:0]  num_nxt;
    logic        fit_s;

    assign last_cbrt = (step == 3'd5);
    assign last_sqrt = (step == 3'd4);

    // Cube root: even step forms y2*(y2+1) on the multiplier, odd step finishes 3*p+1 and the trial subtract.
    assign y2w       = {2'b00, cr_q, 1'b0};
    assign prod_full = y2w * (y2w + 6'd1);
    assign t         = {1'b0, prod_q, 1'b0} + {2'b00, prod_q} + 8'd1;

    always_comb begin
        shamt = 3'd0;
        case (step[2:1])
            2'd0:    shamt = 3'd6;
            2'd1:    shamt = 3'd3;
            default: shamt = 3'd0;
        endcase
    end

    assign rem_sh  = rem_q >> shamt;
    assign fit_c   = (rem_sh >= t);
    assign rem_nxt = rem_q - (t << shamt);
    assign cr_nxt  = {cr_q[1:0], fit_c};
    assign sum     = {1'b0, a_q} + {6'd0, cr_nxt};

    assign trial   = res_q + {1'b0, m_q};
    assign fit_s   = ({1'b0, num_q} >= trial);
    assign num_nxt = num_q - trial[8:0];
    assign res_nxt = fit_s ? ((res_q >> 1) + {1'b0, m_q}) : (res_q >> 1);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i)   state_nxt = CBRT;
            CBRT:    if (last_cbrt) state_nxt = SQRT;
            SQRT:    if (last_sqrt) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o = state;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            step   <= 3'd0;
            a_q    <= 8'd0;
            rem_q  <= 8'd0;
            cr_q   <= 3'd0;
            prod_q <= 6'd0;
            num_q  <= 9'd0;
            m_q    <= 9'd0;
            res_q  <= 10'd0;
            y_bo   <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        a_q   <= a_bi;
                        rem_q <= b_bi;
                        cr_q  <= 3'd0;
                        step  <= 3'd0;
                    end
                end
                CBRT: begin
                    if (!step[0]) begin
                        prod_q <= prod_full;
                    end else begin
                        if (fit_c) rem_q <= rem_nxt;
                        cr_q <= cr_nxt;
                    end
                    if (last_cbrt) begin
                        step  <= 3'd0;
                        num_q <= sum;
                        res_q <= 10'd0;
                        m_q   <= 9'h100;
                    end else begin
                        step <= step + 3'd1;
                    end
                end
                SQRT: begin
                    if (fit_s) num_q <= num_nxt;
                    res_q <= res_nxt;
                    m_q   <= m_q >> 2;
                    if (last_sqrt) begin
                        step <= 3'd0;
                        y_bo <= res_nxt[4:0];
                    end else begin
                        step <= step + 3'd1;
                    end
                end
                default: step <= 3'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_func.sv
// Directed and strided-sweep bench for func; a reference model tracks the expected held result every cycle.
module tb_func;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a_in, b_in;
    logic       start;
    logic [1:0] busy;
    logic [4:0] y;

    int errors = 0;
    int checks = 0;
    int lat0   = -1;

    func dut (
        .clk_i  (clk),
        .rst_i  (rst_n),
        .a_bi   (a_in),
        .b_bi   (b_in),
        .start_i(start),
        .busy_o (busy),
        .y_bo   (y)
    );

    always #5 clk = ~clk;

    function automatic int cbrt_f(input int v);
        int c = 0;
        while ((c + 1) * (c + 1) * (c + 1) <= v) c++;
        return c;
    endfunction

    function automatic int isqrt_f(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    function automatic int model(input int a, input int b);
        return isqrt_f(a + cbrt_f(b));
    endfunction

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model of the handshake: result is fixed when start is sampled idle, published at busy falling to idle.
    int  exp_y     = 0;
    int  pend_y    = 0;
    bit  pend_vld  = 0;
    bit  just_strt = 0;
    logic [1:0] prev_busy = 2'b00;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_y     = 0;
            pend_vld  = 0;
            just_strt = 0;
            prev_busy = 2'b00;
        end else begin
            if (pend_vld && prev_busy != 2'b00 && busy == 2'b00) begin
                exp_y    = pend_y;
                pend_vld = 0;
            end
            chk(y == exp_y[4:0], "y_track", int'(y), exp_y);
            chk(busy != 2'b11, "busy_legal", int'(busy), 0);
            if (just_strt) chk(busy == 2'b01, "busy_after_start", int'(busy), 1);
            just_strt = 0;
            if (busy == 2'b00 && start) begin
                pend_y    = model(int'(a_in), int'(b_in));
                pend_vld  = 1;
                just_strt = 1;
            end
            prev_busy = busy;
        end
    end

    task automatic wait_idle(output int cycles);
        cycles = 1;
        while (busy != 2'b00 && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
        chk(busy == 2'b00, "timeout", int'(busy), 0);
    endtask

    task automatic check_lat(input int cycles);
        if (lat0 < 0) begin
            lat0 = cycles;
            chk(cycles <= 20, "latency_bound", cycles, 20);
        end else begin
            chk(cycles == lat0, "latency_const", cycles, lat0);
        end
    endtask

    task automatic run(input int a, input int b, input int exp, input string name);
        int cyc;
        @(posedge clk); #1;
        a_in = 8'(a); b_in = 8'(b); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a_in = ~a_in; b_in = ~b_in;
        chk(busy == 2'b01, "busy_01", int'(busy), 1);
        wait_idle(cyc);
        check_lat(cyc);
        chk(y == exp[4:0], name, int'(y), exp);
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0; start = 1'b0; a_in = 8'd0; b_in = 8'd0;
        #3;
        chk(busy == 2'b00, "reset_busy", int'(busy), 0);
        chk(y == 5'd0, "reset_y", int'(y), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Model pinned by hand-derived values.
        chk(model(12, 60) == 3, "model_12_60", model(12, 60), 3);
        chk(model(123, 223) == 11, "model_123_223", model(123, 223), 11);
        chk(model(1, 255) == 2, "model_1_255", model(1, 255), 2);

        run(0, 0, 0, "d_0_0");
        run(1, 1, 1, "d_1_1");
        run(12, 60, 3, "d_12_60");
        run(45, 64, 7, "d_45_64");
        run(123, 223, 11, "d_123_223");
        run(255, 255, 16, "d_255_255");
        run(255, 30, 16, "d_255_30");
        run(255, 1, 16, "d_255_1");
        run(30, 255, 6, "d_30_255");
        run(1, 255, 2, "d_1_255");

        // Starts while busy must be ignored.
        @(posedge clk); #1;
        a_in = 8'd45; b_in = 8'd64; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            a_in = 8'd0; b_in = 8'd0; start = 1'b1;
            chk(busy != 2'b00, "busy_held", int'(busy), 1);
            chk(y == 5'd2, "y_hold_busy", int'(y), 2);
        end
        start = 1'b0;
        wait_idle(cyc);
        chk(y == 5'd7, "ignored_start", int'(y), 7);

        // Start held across completion launches the next operation at once.
        @(posedge clk); #1;
        a_in = 8'd12; b_in = 8'd60; start = 1'b1;
        @(posedge clk); #1;
        a_in = 8'd45; b_in = 8'd64;
        wait_idle(cyc);
        chk(y == 5'd3, "held_first", int'(y), 3);
        @(posedge clk); #1;
        chk(busy == 2'b01, "held_restart", int'(busy), 1);
        start = 1'b0;
        wait_idle(cyc);
        chk(y == 5'd7, "held_second", int'(y), 7);

        // Asynchronous reset during the square-root phase.
        @(posedge clk); #1;
        a_in = 8'd123; b_in = 8'd223; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (busy != 2'b10 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk(busy == 2'b10, "reach_sqrt", int'(busy), 2);
        #2 rst_n = 1'b0;
        #1;
        chk(busy == 2'b00, "arst_busy", int'(busy), 0);
        chk(y == 5'd0, "arst_y", int'(y), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        run(123, 223, 11, "after_reset");

        for (int a = 0; a < 256; a += 5)
            for (int b = 0; b < 256; b += 17)
                run(a, b, model(a, b), "sweep");
        repeat (100) begin
            int ra, rb;
            ra = int'($urandom_range(0, 255));
            rb = int'($urandom_range(0, 255));
            run(ra, rb, model(ra, rb), "random");
        end

        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
